// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: decodes the branch condition, detects mispredicts,
// drives a fixed-length flush/redirect, and keeps a 2-bit BHT plus statistics.
module branch_resolve_unit #(
  parameter int PC_W      = 32,
  parameter int IDX_W     = 4,
  parameter int FLUSH_LEN = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             stall,
  input  logic [2:0]       branch_op,
  input  logic             zero,
  input  logic             negative,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [PC_W-1:0]  target_in,
  input  logic             pred_taken_in,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             pred_taken_o,
  output logic             taken_o,
  output logic             flush_o,
  output logic [PC_W-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  typedef enum logic {IDLE, FLUSH} state_e;

  localparam int         BHT_N      = 1 << IDX_W;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_LEN - 1);

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_BNE  = 3'b010;
  localparam logic [2:0] OP_BLTZ = 3'b011;
  localparam logic [2:0] OP_BGEZ = 3'b100;
  localparam logic [2:0] OP_BLEZ = 3'b101;
  localparam logic [2:0] OP_BGTZ = 3'b110;
  localparam logic [2:0] OP_JUMP = 3'b111;

  state_e            state_q, state_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic              taken_q, taken_d;
  logic [PC_W-1:0]   redirect_q, redirect_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;
  logic [1:0]        bht_q [BHT_N];
  logic [1:0]        bht_d [BHT_N];

  logic              resolve;
  logic              cond_taken;
  logic              mispred;
  logic [IDX_W-1:0]  upd_idx;
  logic [IDX_W-1:0]  lookup_idx;
  logic              unused_lookup_bits;

  assign upd_idx    = pc_in[IDX_W+1:2];
  assign lookup_idx = lookup_pc[IDX_W+1:2];
  assign unused_lookup_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign pred_taken_o = bht_q[lookup_idx][1];

  assign resolve = valid_in && !stall && (branch_op != OP_NONE) && (state_q == IDLE);
  assign mispred = resolve && (cond_taken != pred_taken_in);

  always_comb begin
    cond_taken = 1'b0;
    unique case (branch_op)
      OP_BEQ:  cond_taken = zero;
      OP_BNE:  cond_taken = !zero;
      OP_BLTZ: cond_taken = negative;
      OP_BGEZ: cond_taken = !negative;
      OP_BLEZ: cond_taken = negative || zero;
      OP_BGTZ: cond_taken = !negative && !zero;
      OP_JUMP: cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    taken_d       = 1'b0;
    redirect_d    = redirect_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    bht_d         = bht_q;

    if (state_q == FLUSH) begin
      if (flush_cnt_q == 4'd0) state_d = IDLE;
      else                     flush_cnt_d = flush_cnt_q - 4'd1;
    end

    if (resolve) begin
      taken_d = cond_taken;
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + 1'b1;
      if (branch_op != OP_JUMP) begin
        if (cond_taken && bht_q[upd_idx] != 2'b11)
          bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
        else if (!cond_taken && bht_q[upd_idx] != 2'b00)
          bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
      end
      if (mispred) begin
        state_d     = FLUSH;
        flush_cnt_d = FLUSH_INIT;
        redirect_d  = cond_taken ? target_in : pc_in + PC_W'(4);
        if (mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: the BHT is small enough to live in flops, so it is reset like any
  // other register; a RAM-backed table would need an explicit init sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      flush_cnt_q   <= 4'd0;
      taken_q       <= 1'b0;
      redirect_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      taken_q       <= taken_d;
      redirect_q    <= redirect_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      bht_q         <= bht_d;
    end
  end

  assign taken_o       = taken_q;
  assign flush_o       = (state_q == FLUSH);
  assign redirect_pc_o = redirect_q;
  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; a second instance with 4-bit
// statistics counters shares the stimulus to exercise counter saturation.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  branch_op = 3'b000;
  logic        zero = 1'b0;
  logic        negative = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] target_in = '0;
  logic        pred_taken_in = 1'b0;
  logic [31:0] lookup_pc = '0;

  logic        pred_taken_o, taken_o, flush_o;
  logic [31:0] redirect_pc_o;
  logic [15:0] branch_cnt_o, mispred_cnt_o;

  logic        s_pred_taken_o, s_taken_o, s_flush_o;
  logic [31:0] s_redirect_pc_o;
  logic [3:0]  s_branch_cnt_o, s_mispred_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall),
    .branch_op(branch_op), .zero(zero), .negative(negative),
    .pc_in(pc_in), .target_in(target_in), .pred_taken_in(pred_taken_in),
    .lookup_pc(lookup_pc), .pred_taken_o(pred_taken_o), .taken_o(taken_o),
    .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
    .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  branch_resolve_unit #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall),
    .branch_op(branch_op), .zero(zero), .negative(negative),
    .pc_in(pc_in), .target_in(target_in), .pred_taken_in(pred_taken_in),
    .lookup_pc(lookup_pc), .pred_taken_o(s_pred_taken_o), .taken_o(s_taken_o),
    .flush_o(s_flush_o), .redirect_pc_o(s_redirect_pc_o),
    .branch_cnt_o(s_branch_cnt_o), .mispred_cnt_o(s_mispred_cnt_o)
  );

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    stall    = 1'b0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic z, input logic n,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    valid_in      = 1'b1;
    branch_op     = op;
    zero          = z;
    negative      = n;
    pc_in         = pc;
    target_in     = tgt;
    pred_taken_in = pred;
  endtask

  task automatic test_reset();
    do_reset();
    lookup_pc = 32'h100;
    #1;
    chk("reset_pred", 32'(pred_taken_o), 32'd0);
    chk("reset_branch_cnt", 32'(branch_cnt_o), 32'd0);
    chk("reset_mispred_cnt", 32'(mispred_cnt_o), 32'd0);
    chk("reset_taken", 32'(taken_o), 32'd0);
    chk("reset_flush", 32'(flush_o), 32'd0);
    chk("reset_redirect", redirect_pc_o, 32'd0);
  endtask

  task automatic test_beq_mispredict();
    do_reset();
    lookup_pc = 32'h100;
    drive(3'b001, 1'b1, 1'b0, 32'h100, 32'h200, 1'b0);
    #1;
    chk("beq_pred_pre_update", 32'(pred_taken_o), 32'd0);
    tick();
    valid_in = 1'b0;
    chk("beq_taken", 32'(taken_o), 32'd1);
    chk("beq_flush1", 32'(flush_o), 32'd1);
    chk("beq_redirect", redirect_pc_o, 32'h200);
    chk("beq_mispred_cnt", 32'(mispred_cnt_o), 32'd1);
    chk("beq_branch_cnt", 32'(branch_cnt_o), 32'd1);
    chk("beq_pred_post_update", 32'(pred_taken_o), 32'd1);
    tick();
    chk("beq_flush2", 32'(flush_o), 32'd1);
    chk("beq_taken_pulse_end", 32'(taken_o), 32'd0);
    tick();
    chk("beq_flush_end", 32'(flush_o), 32'd0);
  endtask

  task automatic test_bht_saturation();
    do_reset();
    lookup_pc = 32'h104;
    drive(3'b010, 1'b1, 1'b0, 32'h104, 32'h400, 1'b0);
    tick();
    chk("bne1_taken", 32'(taken_o), 32'd0);
    chk("bne1_flush", 32'(flush_o), 32'd0);
    tick();
    chk("bne2_taken", 32'(taken_o), 32'd0);
    chk("bne2_flush", 32'(flush_o), 32'd0);
    chk("bne_branch_cnt", 32'(branch_cnt_o), 32'd2);
    chk("bne_mispred_cnt", 32'(mispred_cnt_o), 32'd0);
    // Counter is 0 if it saturated; one taken update then gives 1 (pred 0).
    drive(3'b001, 1'b1, 1'b0, 32'h104, 32'h400, 1'b1);
    tick();
    chk("bht_low_sat_taken", 32'(taken_o), 32'd1);
    chk("bht_low_sat_pred", 32'(pred_taken_o), 32'd0);
    tick();
    chk("bht_up_pred_2", 32'(pred_taken_o), 32'd1);
    tick();
    tick();
    // Counter should now sit at 3; two not-taken updates bring it to 1.
    drive(3'b001, 1'b0, 1'b0, 32'h104, 32'h400, 1'b0);
    tick();
    chk("bht_high_sat_pred_a", 32'(pred_taken_o), 32'd1);
    tick();
    valid_in = 1'b0;
    chk("bht_high_sat_pred_b", 32'(pred_taken_o), 32'd0);
    chk("bht_seq_branch_cnt", 32'(branch_cnt_o), 32'd8);
    chk("bht_seq_mispred_cnt", 32'(mispred_cnt_o), 32'd0);
  endtask

  task automatic test_decode_back_to_back();
    // {op, zero, negative, expected taken}
    logic [5:0] vec [12] = '{
      {3'b001, 1'b0, 1'b0, 1'b0}, {3'b010, 1'b0, 1'b0, 1'b1},
      {3'b011, 1'b0, 1'b1, 1'b1}, {3'b100, 1'b0, 1'b1, 1'b0},
      {3'b101, 1'b1, 1'b0, 1'b1}, {3'b101, 1'b0, 1'b0, 1'b0},
      {3'b101, 1'b0, 1'b1, 1'b1}, {3'b110, 1'b0, 1'b0, 1'b1},
      {3'b110, 1'b1, 1'b0, 1'b0}, {3'b110, 1'b0, 1'b1, 1'b0},
      {3'b111, 1'b0, 1'b0, 1'b1}, {3'b000, 1'b1, 1'b0, 1'b0}
    };
    logic [5:0] row;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      row = vec[i];
      drive(row[5:3], row[2], row[1], 32'h200, 32'h800, row[0]);
      tick();
      chk($sformatf("decode_taken_%0d", i), 32'(taken_o), 32'(row[0]));
      chk($sformatf("decode_flush_%0d", i), 32'(flush_o), 32'd0);
    end
    valid_in = 1'b0;
    chk("decode_branch_cnt", 32'(branch_cnt_o), 32'd11);
    // Stall blocks resolution.
    drive(3'b111, 1'b0, 1'b0, 32'h200, 32'h800, 1'b0);
    stall = 1'b1;
    tick();
    stall    = 1'b0;
    valid_in = 1'b0;
    chk("stall_taken", 32'(taken_o), 32'd0);
    chk("stall_flush", 32'(flush_o), 32'd0);
    chk("stall_branch_cnt", 32'(branch_cnt_o), 32'd11);
  endtask

  task automatic test_flush_ignore();
    do_reset();
    // Correctly predicted JUMP must leave its BHT entry untouched.
    lookup_pc = 32'h50;
    drive(3'b111, 1'b0, 1'b0, 32'h50, 32'h900, 1'b1);
    tick();
    chk("jump_no_bht_update", 32'(pred_taken_o), 32'd0);
    chk("jump_no_flush", 32'(flush_o), 32'd0);
    drive(3'b100, 1'b0, 1'b0, 32'h10, 32'h300, 1'b1);
    tick();
    chk("bgez_flush", 32'(flush_o), 32'd0);
    drive(3'b111, 1'b0, 1'b0, 32'h10, 32'h300, 1'b0);
    tick();
    chk("jmp_flush1", 32'(flush_o), 32'd1);
    chk("jmp_redirect", redirect_pc_o, 32'h300);
    // BEQ that would mispredict, held valid through the flush; stall toggles.
    lookup_pc = 32'h40;
    drive(3'b001, 1'b1, 1'b0, 32'h40, 32'h200, 1'b0);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    chk("jmp_flush2", 32'(flush_o), 32'd1);
    chk("ignored_taken", 32'(taken_o), 32'd0);
    tick();
    valid_in = 1'b0;
    chk("jmp_flush_end", 32'(flush_o), 32'd0);
    chk("ignored_branch_cnt", 32'(branch_cnt_o), 32'd3);
    chk("ignored_mispred_cnt", 32'(mispred_cnt_o), 32'd1);
    chk("ignored_bht", 32'(pred_taken_o), 32'd0);
    chk("ignored_redirect", redirect_pc_o, 32'h300);
  endtask

  task automatic test_pc_wrap();
    drive(3'b001, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h500, 1'b1);
    tick();
    valid_in = 1'b0;
    chk("wrap_redirect", redirect_pc_o, 32'h0);
    chk("wrap_flush", 32'(flush_o), 32'd1);
    tick();
    tick();
    chk("wrap_flush_end", 32'(flush_o), 32'd0);
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    lookup_pc = 32'h30;
    drive(3'b001, 1'b1, 1'b0, 32'h30, 32'h700, 1'b1);
    tick();
    chk("pre_rst_pred", 32'(pred_taken_o), 32'd1);
    drive(3'b011, 1'b0, 1'b0, 32'h20, 32'h600, 1'b1);
    tick();
    chk("bltz_redirect", redirect_pc_o, 32'h24);
    chk("bltz_taken", 32'(taken_o), 32'd0);
    chk("bltz_flush", 32'(flush_o), 32'd1);
    chk("bltz_mispred_cnt", 32'(mispred_cnt_o), 32'd1);
    // Reset in the first flush cycle, with a would-be resolution present.
    drive(3'b001, 1'b1, 1'b0, 32'h30, 32'h700, 1'b0);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    valid_in = 1'b0;
    chk("rst_mid_flush", 32'(flush_o), 32'd0);
    chk("rst_mid_taken", 32'(taken_o), 32'd0);
    chk("rst_mid_branch_cnt", 32'(branch_cnt_o), 32'd0);
    chk("rst_mid_mispred_cnt", 32'(mispred_cnt_o), 32'd0);
    chk("rst_mid_redirect", redirect_pc_o, 32'd0);
    chk("rst_mid_bht", 32'(pred_taken_o), 32'd0);
  endtask

  task automatic test_counter_saturation();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(3'b111, 1'b0, 1'b0, 32'h80, 32'hA00, 1'b0);
      tick();
      valid_in = 1'b0;
      tick();
      tick();
    end
    chk("sat_small_branch_cnt", 32'(s_branch_cnt_o), 32'd15);
    chk("sat_small_mispred_cnt", 32'(s_mispred_cnt_o), 32'd15);
    chk("sat_wide_branch_cnt", 32'(branch_cnt_o), 32'd17);
    chk("sat_wide_mispred_cnt", 32'(mispred_cnt_o), 32'd17);
    tick();
    tick();
    chk("sat_small_branch_hold", 32'(s_branch_cnt_o), 32'd15);
    chk("sat_small_mispred_hold", 32'(s_mispred_cnt_o), 32'd15);
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_bht_saturation();
    test_decode_back_to_back();
    test_flush_ignore();
    test_pc_wrap();
    test_reset_mid_flush();
    test_counter_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter PC_W, default 32: width of every PC and target bus.
REQ-002 Parameter IDX_W, default 4: BHT index width; the BHT holds 2^IDX_W two-bit counters.
REQ-003 Parameter FLUSH_LEN, default 2, legal range 1..15: number of cycles flush_o stays high per mispredict.
REQ-004 Parameter CNT_W, default 16: width of the statistics counters.
REQ-005 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port valid_in, input, 1: a branch-stage instruction is present this cycle.
REQ-008 Port stall, input, 1: pipeline stall; blocks resolution this cycle.
REQ-009 Port branch_op, input, 3: 000 none, 001 BEQ, 010 BNE, 011 BLTZ, 100 BGEZ, 101 BLEZ, 110 BGTZ, 111 JUMP.
REQ-010 Port zero, input, 1: ALU result equals zero.
REQ-011 Port negative, input, 1: ALU result sign bit.
REQ-012 Port pc_in, input, PC_W: PC of the resolving instruction.
REQ-013 Port target_in, input, PC_W: computed branch target.
REQ-014 Port pred_taken_in, input, 1: prediction used at fetch for this instruction.
REQ-015 Port lookup_pc, input, PC_W: fetch-stage PC for prediction.
REQ-016 Port pred_taken_o, output, 1: combinational prediction for lookup_pc.
REQ-017 Port taken_o, output, 1: registered resolved-taken pulse.
REQ-018 Port flush_o, output, 1: registered pipeline flush.
REQ-019 Port redirect_pc_o, output, PC_W: registered correct next PC.
REQ-020 Port branch_cnt_o, output, CNT_W: count of resolved branches.
REQ-021 Port mispred_cnt_o, output, CNT_W: count of mispredicts.

Function
REQ-022 A resolution occurs in cycle N iff valid_in=1, stall=0, branch_op!=000 and the FSM is in IDLE.
REQ-023 The taken condition SHALL be decoded per branch_op as follows:
- BEQ: zero.
- BNE: !zero.
- BLTZ: negative.
- BGEZ: !negative.
- BLEZ: negative|zero.
- BGTZ: !negative&!zero.
- JUMP: 1.
REQ-024 On a resolution in cycle N, taken_o SHALL be 1 in cycle N+1 iff the branch is taken; otherwise taken_o is 0 in N+1.
REQ-025 Mispredict SHALL be defined as taken != pred_taken_in.
REQ-026 On a mispredict, redirect_pc_o SHALL load target_in if taken, else pc_in+4 (modulo 2^PC_W), valid from N+1; redirect_pc_o holds its value otherwise.
REQ-027 FSM states are IDLE and FLUSH:
- IDLE to FLUSH on a mispredict resolution.
- FLUSH loads a down-counter with FLUSH_LEN-1 and decrements each cycle.
- FLUSH returns to IDLE at the edge where the counter is 0.
- flush_o=1 exactly while in FLUSH, i.e. FLUSH_LEN cycles starting at N+1.
REQ-028 While in FLUSH, valid_in SHALL be ignored: no resolution, no BHT update, no count; stall does not pause the flush sequence.
REQ-029 BHT index SHALL be pc[IDX_W+1:2] for both lookup_pc and pc_in.
REQ-030 pred_taken_o SHALL equal bit 1 of the indexed counter.
REQ-031 Conditional ops (001–110) SHALL update the pc_in-indexed counter at the end of cycle N: +1 if taken, saturating at 3; -1 if not taken, saturating at 0.
REQ-032 JUMP SHALL NOT update the BHT.
REQ-033 A lookup and an update to the same index in the same cycle SHALL return the pre-update value; the new value is visible from N+1.
REQ-034 branch_cnt_o SHALL increment by 1 per resolution; mispred_cnt_o SHALL increment by 1 per mispredict resolution.
REQ-035 Both statistics counters SHALL saturate at all-ones.

Reset
REQ-036 While rst=1 at a rising edge, the next cycle SHALL show the following, overriding any concurrent resolution:
- FSM in IDLE.
- taken_o=0, flush_o=0, redirect_pc_o=0.
- Both statistics counters 0.
- Every BHT counter 2'b01 (weakly not-taken).
REQ-037 A reset asserted mid-FLUSH SHALL abort the flush: flush_o=0 in the cycle after the reset edge.

Verification
REQ-038 Reset, then lookup_pc=0x100 -> pred_taken_o=0; branch_cnt_o=0; mispred_cnt_o=0.
REQ-039 BEQ, zero=1, pred_taken_in=0, pc_in=0x100, target_in=0x200 -> N+1: taken_o=1, flush_o=1 for 2 cycles, redirect_pc_o=0x200, mispred_cnt_o=1; afterwards lookup_pc=0x100 gives pred_taken_o=1 (counter 2).
REQ-040 BNE, zero=1, pred_taken_in=0, pc_in=0x104, issued twice -> taken_o=0, no flush, BHT[1] goes 1 then 0 (saturates), branch_cnt_o=2, mispred_cnt_o=0.
REQ-041 BGEZ, negative=0, pred_taken_in=1 mispredicted as JUMP with pred_taken_in=0 at pc_in=0x10 -> flush pulse; valid_in=1 BEQ during both flush cycles -> ignored, counts unchanged, BHT unchanged.
REQ-042 BLTZ, negative=0, pred_taken_in=1, pc_in=0x20 -> redirect_pc_o=0x24; rst=1 in the first flush cycle -> flush_o=0 the next cycle, counters 0.
REQ-043 With CNT_W=4: 17 mispredicting JUMPs, each separated by a completed flush -> branch_cnt_o=15 and mispred_cnt_o=15, held.
